// File: rtl/mul_div_unit_if.sv
// Handshake and result bundle between the E-stage controller and the HI/LO multiply/divide unit.
interface mul_div_unit_if;
  logic        start;
  logic [10:0] hiloop;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, hiloop, rs_val, rt_val, input busy, hi, lo);
  modport slave  (input start, hiloop, rs_val, rt_val, output busy, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; the result is computed at the
// start edge and committed to HI/LO when the busy window expires.
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  mul_div_unit_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  // One-hot Hilo_* codes carried on hiloop.
  localparam logic [10:0] HILO_MULT  = 11'h001;
  localparam logic [10:0] HILO_MULTU = 11'h002;
  localparam logic [10:0] HILO_DIV   = 11'h004;
  localparam logic [10:0] HILO_DIVU  = 11'h008;
  localparam logic [10:0] HILO_TOHI  = 11'h010;
  localparam logic [10:0] HILO_TOLO  = 11'h020;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic             busy_q, busy_nx;
  logic [31:0]      hi_q, hi_nx;
  logic [31:0]      lo_q, lo_nx;
  logic [63:0]      pend_q, pend_nx;

  logic        is_mul, is_div, dvs_zero;
  logic [31:0] dvs_safe;
  logic [63:0] prod_s, prod_u;
  logic [32:0] quo_s, rem_s;
  logic [31:0] quo_u, rem_u;
  logic [63:0] op_result;

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Datapath: 64-bit result as {hi, lo}. Divider sees 1 instead of 0 to keep it defined;
  // the zero-divisor case is handled by preserving HI/LO. 33-bit signed divide keeps
  // 0x80000000 / -1 from overflowing.
  always_comb begin
    is_mul    = (bus.hiloop == HILO_MULT) || (bus.hiloop == HILO_MULTU);
    is_div    = (bus.hiloop == HILO_DIV)  || (bus.hiloop == HILO_DIVU);
    dvs_zero  = (bus.rt_val == 32'd0);
    dvs_safe  = dvs_zero ? 32'd1 : bus.rt_val;
    prod_s    = 64'($signed({{32{bus.rs_val[31]}}, bus.rs_val}) *
                    $signed({{32{bus.rt_val[31]}}, bus.rt_val}));
    prod_u    = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
    quo_s     = 33'($signed({bus.rs_val[31], bus.rs_val}) / $signed({dvs_safe[31], dvs_safe}));
    rem_s     = 33'($signed({bus.rs_val[31], bus.rs_val}) % $signed({dvs_safe[31], dvs_safe}));
    quo_u     = bus.rs_val / dvs_safe;
    rem_u     = bus.rs_val % dvs_safe;
    op_result = 64'd0;
    unique case (bus.hiloop)
      HILO_MULT:  op_result = prod_s;
      HILO_MULTU: op_result = prod_u;
      HILO_DIV:   op_result = {rem_s[31:0], quo_s[31:0]};
      HILO_DIVU:  op_result = {rem_u, quo_u};
      default:    op_result = 64'd0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx = state;
    count_nx = count;
    hi_nx    = hi_q;
    lo_nx    = lo_q;
    pend_nx  = pend_q;
    unique case (state)
      IDLE: begin
        if (bus.start && is_mul) begin
          state_nx = MULT;
          count_nx = CNT_W'(MULT_CYCLES);
          pend_nx  = op_result;
        end else if (bus.start && is_div) begin
          state_nx = DIV;
          count_nx = CNT_W'(DIV_CYCLES);
          pend_nx  = dvs_zero ? {hi_q, lo_q} : op_result;
        end else if (!bus.start && (bus.hiloop == HILO_TOHI)) begin
          hi_nx = bus.rs_val;
        end else if (!bus.start && (bus.hiloop == HILO_TOLO)) begin
          lo_nx = bus.rs_val;
        end
      end
      MULT, DIV: begin
        if (count == CNT_W'(1)) begin
          hi_nx    = pend_q[63:32];
          lo_nx    = pend_q[31:0];
          count_nx = '0;
          state_nx = IDLE;
        end else begin
          count_nx = count - CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      count  <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      pend_q <= '0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      busy_q <= busy_nx;
      hi_q   <= hi_nx;
      lo_q   <= lo_nx;
      pend_q <= pend_nx;
    end
  end

endmodule
